key_chunk_dispatcher: RTL and testbench
=======================================

Name: key_chunk_dispatcher

Overview:
- Upstream feeder for the multi-core RC4 cracking array.
- Partitions the secret-key search space into fixed-size contiguous chunks and hands them to cores on request.
- Uses round-robin arbitration, so no core idles while keys remain, and no core receives more than its fair share.
- Halts all dispatch once any core reports a solution (the array's global stop) or the key space is exhausted.

Parameters:
- NUM_CORES, 4: number of cracking cores served.
- KEY_W, 24: key width in bits.
- CHUNK_LOG2, 12: log2 of keys per chunk (default 4096).
- KEY_LIMIT, 24'h3FFFFF: highest key to search, inclusive.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begin or restart a search from key 0.
- stop  in  1  level; any core has found the solution.
- core_req  in  NUM_CORES  level per core; the core is idle and wants a chunk.
- grant  out  NUM_CORES  one-hot, one-cycle pulse; chunk issued to that core.
- chunk_base  out  KEY_W  first key of the issued chunk; valid with grant.
- chunk_last  out  KEY_W  last key of the issued chunk, inclusive; valid with grant.
- busy  out  1  in DISPATCH state.
- exhausted  out  1  sticky; final chunk issued with no stop seen.
- chunks_issued  out  KEY_W-CHUNK_LOG2+1  total grants since last start.

Behaviour:
- Reset (async) values:
  - All outputs 0.
  - state=IDLE, next_base=0, rr_ptr=0.
- next_base is KEY_W+1 bits wide so the final increment cannot wrap.
- States:
  - IDLE: start moves to DISPATCH. next_base, chunks_issued and rr_ptr clear to 0; exhausted clears.
  - DISPATCH: each cycle, search core_req round-robin starting at rr_ptr. The request of the core granted in the previous cycle is masked, which gives the core one cycle to drop req.
    - On a winner w, the next cycle carries grant[w]=1, chunk_base=next_base, and chunk_last=min(next_base+2^CHUNK_LOG2-1, KEY_LIMIT).
    - In that same update, next_base += 2^CHUNK_LOG2, rr_ptr=(w+1) mod NUM_CORES, and chunks_issued increments.
    - At most one grant per cycle. Latency from request seen to grant is 1 cycle.
    - If the issued chunk_last==KEY_LIMIT, go to EXHAUSTED.
  - EXHAUSTED: exhausted=1; no grants.
  - STOPPED: no grants; chunk outputs hold their last values.
  - From EXHAUSTED or STOPPED, start restarts exactly as from IDLE.
- stop handling:
  - stop high in DISPATCH or EXHAUSTED moves to STOPPED.
  - stop combinationally blocks any arbitration win in that same cycle, so no grant appears in the following cycle.
  - stop in IDLE is ignored.
  - start and stop asserted together: stop wins and the state goes to or stays STOPPED. From IDLE the start is ignored.
- KEY_LIMIT+1 need not be a multiple of the chunk size; the final chunk is clamped.
- When no core requests, nothing changes.
- A grant is never issued for a base above KEY_LIMIT.
- Reset mid-dispatch aborts immediately; cores must also be reset.

Optional Feature:
- Macro: DISPATCH_WATCHDOG_EN.
- When defined:
  - Each core has a cycle counter (32 bits) that starts on its grant and clears when it next requests.
  - Adds parameter WDOG_LIMIT, default 32'd50_000_000.
  - Adds output wdog_err[NUM_CORES], sticky until start.
  - A counter exceeding WDOG_LIMIT sets that core's wdog_err bit and masks the core from further grants.
- When undefined: there are no counters, wdog_err is absent, and port lists and logic are otherwise identical.

Decomposition:
- Package crack_pkg holds:
  - the key_t typedef (logic [KEY_W-1:0]);
  - KEY_W and KEY_LIMIT defaults;
  - the dispatch_state_e enum (IDLE, DISPATCH, EXHAUSTED, STOPPED).
- Sub-module rr_arbiter: parameterised NUM_CORES, purely a masked round-robin pick. Inputs are req, mask and rr_ptr; outputs are onehot and valid.

Test Plan:
- Ordering and clamping, NUM_CORES=4, CHUNK_LOG2=4, KEY_LIMIT=8'h3F. Stimulus: start, then all core_req held high. Required response:
  - grants in order core0, 1, 2, 3;
  - bases 0x00, 0x10, 0x20, 0x30 with lasts 0x0F, 0x1F, 0x2F, 0x3F;
  - exhausted=1 after the fourth grant;
  - chunks_issued=4.
- Non-aligned limit, KEY_LIMIT=8'h27. Required response: the third grant is base 0x20, last 0x27; then EXHAUSTED with no fourth grant.
- Fairness. Stimulus: only core2 requesting for 3 slots, then core1 and core3 together. Required response: core2 receives bases 0x00 and 0x10 (masked in the cycle after each grant). After rr_ptr=3, core3 wins before core1.
- stop collision. Stimulus: stop asserted in the same cycle as core_req=4'b0001. Required response: no grant follows; state=STOPPED; busy=0; outputs hold.
- Restart. Stimulus: start pulse from STOPPED. Required response: next grant base is 0x00; chunks_issued restarts from 0; exhausted clears.
- Reset mid-operation. Stimulus: reset asserted asynchronously between clock edges during DISPATCH. Required response: grant, busy and chunk outputs are 0 before the next edge, with state=IDLE.
- Watchdog, with DISPATCH_WATCHDOG_EN and WDOG_LIMIT=20. Stimulus: core0 is granted and never re-requests. Required response: wdog_err[0] is set at cycle 21 after its grant, and core0 is never granted again.

Source files
------------

// File: rtl/crack_pkg.sv
// Shared types and default sizing for the RC4 cracking array front end.
// Imported by the key chunk dispatcher and its arbiter.
package crack_pkg;

  localparam int          DEFAULT_KEY_W     = 24;
  localparam logic [23:0] DEFAULT_KEY_LIMIT = 24'h3FFFFF;

  typedef logic [DEFAULT_KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISPATCH  = 2'd1,
    EXHAUSTED = 2'd2,
    STOPPED   = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Masked round-robin pick: first unmasked requester at or after rr_ptr wins.
// Purely combinational; the caller owns the pointer and any registering.
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  localparam int PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [NUM_CORES-1:0] mask,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] onehot,
  output logic                 valid
);

  logic [NUM_CORES-1:0] eligible;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    eligible = req & ~mask;
    onehot   = '0;
    valid    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_CORES;
      if (!valid && eligible[idx]) begin
        onehot[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_chunk_dispatcher.sv
// Hands contiguous key chunks to idle cracking cores in round-robin order until
// the key space runs out or a core reports a hit. DISPATCH_WATCHDOG_EN adds per-core hang detection.
module key_chunk_dispatcher
  import crack_pkg::*;
#(
  parameter int             NUM_CORES  = 4,
  parameter int             KEY_W      = DEFAULT_KEY_W,
  parameter int             CHUNK_LOG2 = 12,
  parameter logic [KEY_W-1:0] KEY_LIMIT = DEFAULT_KEY_LIMIT
`ifdef DISPATCH_WATCHDOG_EN
  , parameter logic [31:0]  WDOG_LIMIT = 32'd50_000_000
`endif
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_CORES-1:0]     core_req,
  output logic [NUM_CORES-1:0]     grant,
  output logic [KEY_W-1:0]         chunk_base,
  output logic [KEY_W-1:0]         chunk_last,
  output logic                     busy,
  output logic                     exhausted,
  output logic [KEY_W-CHUNK_LOG2:0] chunks_issued
`ifdef DISPATCH_WATCHDOG_EN
  , output logic [NUM_CORES-1:0]   wdog_err
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = KEY_W - CHUNK_LOG2 + 1;
  localparam logic [KEY_W:0] CHUNK_SPAN = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;
  localparam logic [KEY_W:0] LIMIT_X    = {1'b0, KEY_LIMIT};

  dispatch_state_e      state_q, state_d;
  logic [KEY_W:0]       next_base_q, next_base_d;   // one spare bit: final increment cannot wrap
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [KEY_W-1:0]     chunk_base_q, chunk_base_d;
  logic [KEY_W-1:0]     chunk_last_q, chunk_last_d;
  logic                 exhausted_q, exhausted_d;
  logic [CNT_W-1:0]     issued_q, issued_d;

  logic [NUM_CORES-1:0] arb_mask, arb_onehot;
  logic                 arb_valid, do_restart, do_issue;
  logic [PTR_W-1:0]     win_idx;
  logic [KEY_W:0]       span_end, clamp_last;

`ifdef DISPATCH_WATCHDOG_EN
  logic [NUM_CORES-1:0] wdog_err_q, wdog_err_d, wdog_act_q, wdog_act_d;
  logic [31:0]          wdog_cnt_q [NUM_CORES];
  logic [31:0]          wdog_cnt_d [NUM_CORES];
  assign arb_mask = grant_q | wdog_err_q;
  assign wdog_err = wdog_err_q;
`else
  assign arb_mask = grant_q;
`endif

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .req    (core_req),
    .mask   (arb_mask),
    .rr_ptr (rr_ptr_q),
    .onehot (arb_onehot),
    .valid  (arb_valid)
  );

  assign span_end   = next_base_q + CHUNK_SPAN - 1'b1;
  assign clamp_last = (span_end > LIMIT_X) ? LIMIT_X : span_end;
  // stop vetoes the win combinationally so no grant follows a stop cycle.
  assign do_issue   = arb_valid && (state_q == DISPATCH) && !stop && !start &&
                      (next_base_q <= LIMIT_X);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (arb_onehot[i]) win_idx = PTR_W'(i);
  end

  always_comb begin
    state_d      = state_q;
    next_base_d  = next_base_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = '0;
    chunk_base_d = chunk_base_q;
    chunk_last_d = chunk_last_q;
    exhausted_d  = exhausted_q;
    issued_d     = issued_q;
    do_restart   = 1'b0;

    case (state_q)
      IDLE:    do_restart = start && !stop;
      default: if (stop) state_d = STOPPED;
               else      do_restart = start;
    endcase

    if (do_restart) begin
      state_d     = DISPATCH;
      next_base_d = '0;
      rr_ptr_d    = '0;
      exhausted_d = 1'b0;
      issued_d    = '0;
    end else if (do_issue) begin
      grant_d      = arb_onehot;
      chunk_base_d = next_base_q[KEY_W-1:0];
      chunk_last_d = clamp_last[KEY_W-1:0];
      next_base_d  = next_base_q + CHUNK_SPAN;
      rr_ptr_d     = (int'(win_idx) == NUM_CORES - 1) ? '0 : win_idx + PTR_W'(1);
      issued_d     = issued_q + CNT_W'(1);
      if (clamp_last == LIMIT_X) begin
        state_d     = EXHAUSTED;
        exhausted_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      next_base_q  <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      chunk_base_q <= '0;
      chunk_last_q <= '0;
      exhausted_q  <= 1'b0;
      issued_q     <= '0;
    end else begin
      state_q      <= state_d;
      next_base_q  <= next_base_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      chunk_base_q <= chunk_base_d;
      chunk_last_q <= chunk_last_d;
      exhausted_q  <= exhausted_d;
      issued_q     <= issued_d;
    end
  end

`ifdef DISPATCH_WATCHDOG_EN
  // A core's timer runs from its grant until it asks again; req still high while the grant is shown is ignored.
  always_comb begin
    wdog_err_d = wdog_err_q;
    wdog_act_d = wdog_act_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      wdog_cnt_d[i] = wdog_cnt_q[i];
      if (do_restart) begin
        wdog_err_d[i] = 1'b0;
        wdog_act_d[i] = 1'b0;
        wdog_cnt_d[i] = '0;
      end else if (grant_d[i]) begin
        wdog_act_d[i] = 1'b1;
        wdog_cnt_d[i] = '0;
      end else if (core_req[i] && !grant_q[i]) begin
        wdog_act_d[i] = 1'b0;
        wdog_cnt_d[i] = '0;
      end else if (wdog_act_q[i] && !wdog_err_q[i]) begin
        wdog_cnt_d[i] = wdog_cnt_q[i] + 32'd1;
        if (wdog_cnt_d[i] > WDOG_LIMIT) wdog_err_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wdog_err_q <= '0;
      wdog_act_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) wdog_cnt_q[i] <= '0;
    end else begin
      wdog_err_q <= wdog_err_d;
      wdog_act_q <= wdog_act_d;
      for (int i = 0; i < NUM_CORES; i++) wdog_cnt_q[i] <= wdog_cnt_d[i];
    end
  end
`endif

  assign grant         = grant_q;
  assign chunk_base    = chunk_base_q;
  assign chunk_last    = chunk_last_q;
  assign busy          = (state_q == DISPATCH);
  assign exhausted     = exhausted_q;
  assign chunks_issued = issued_q;

endmodule

// File: tb/tb_key_chunk_dispatcher.sv
// Scoreboard bench: two dispatchers (limits 0x3F and 0x27) share one stimulus stream;
// expected grants are queued as requests are driven and popped when grants appear.
module tb_key_chunk_dispatcher;
  import crack_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [3:0] core_req;

  logic [3:0] grant_a, grant_b;
  logic [7:0] base_a, last_a, base_b, last_b;
  logic       busy_a, busy_b, exh_a, exh_b;
  logic [4:0] iss_a, iss_b;
`ifdef DISPATCH_WATCHDOG_EN
  logic [3:0] wdog_a, wdog_b;
`endif

  always #5 clk = ~clk;

  key_chunk_dispatcher #(.NUM_CORES(4), .KEY_W(8), .CHUNK_LOG2(4), .KEY_LIMIT(8'h3F)) dut_a (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .core_req(core_req),
    .grant(grant_a), .chunk_base(base_a), .chunk_last(last_a), .busy(busy_a),
    .exhausted(exh_a), .chunks_issued(iss_a)
`ifdef DISPATCH_WATCHDOG_EN
    , .wdog_err(wdog_a)
`endif
  );

  key_chunk_dispatcher #(.NUM_CORES(4), .KEY_W(8), .CHUNK_LOG2(4), .KEY_LIMIT(8'h27)) dut_b (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .core_req(core_req),
    .grant(grant_b), .chunk_base(base_b), .chunk_last(last_b), .busy(busy_b),
    .exhausted(exh_b), .chunks_issued(iss_b)
`ifdef DISPATCH_WATCHDOG_EN
    , .wdog_err(wdog_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] g;
    logic [7:0] base;
    logic [7:0] last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic expect_grant(input bit to_b, input int core, input int base, input int last);
    exp_t e;
    e.g    = 4'b0001 << core;
    e.base = 8'(base);
    e.last = 8'(last);
    if (to_b) q_b.push_back(e);
    else      q_a.push_back(e);
  endtask

  // Outputs are sampled on the falling edge, half a cycle after they change.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (grant_a !== 4'b0000) begin
        if (q_a.size() == 0) check("a_unexpected_grant", grant_a, 32'h0);
        else begin
          e = q_a.pop_front();
          check("a_grant", grant_a, e.g);
          check("a_base", base_a, e.base);
          check("a_last", last_a, e.last);
        end
      end
      if (grant_b !== 4'b0000) begin
        if (q_b.size() == 0) check("b_unexpected_grant", grant_b, 32'h0);
        else begin
          e = q_b.pop_front();
          check("b_grant", grant_b, e.g);
          check("b_base", base_b, e.base);
          check("b_last", last_b, e.last);
        end
      end
    end
  end

  task automatic step(input logic s, input logic p, input logic [3:0] r);
    start    = s;
    stop     = p;
    core_req = r;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; core_req = 4'b0000;
    #12;
    check("rst_grant", grant_a, 32'h0);
    check("rst_base", base_a, 32'h0);
    check("rst_last", last_a, 32'h0);
    check("rst_busy", busy_a, 32'h0);
    check("rst_exh", exh_a, 32'h0);
    check("rst_issued", iss_a, 32'h0);
    check("rst_state", dut_a.state_q, IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Ordering and clamping: all cores request continuously.
    expect_grant(0, 0, 8'h00, 8'h0F); expect_grant(0, 1, 8'h10, 8'h1F);
    expect_grant(0, 2, 8'h20, 8'h2F); expect_grant(0, 3, 8'h30, 8'h3F);
    expect_grant(1, 0, 8'h00, 8'h0F); expect_grant(1, 1, 8'h10, 8'h1F);
    expect_grant(1, 2, 8'h20, 8'h27);
    step(1'b1, 1'b0, 4'b1111);
    repeat (6) step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 4'b0000);
    check("order_exh_a", exh_a, 32'h1);
    check("order_exh_b", exh_b, 32'h1);
    check("order_issued_a", iss_a, 32'd4);
    check("order_issued_b", iss_b, 32'd3);
    check("order_busy_a", busy_a, 32'h0);
    check("order_state_b", dut_b.state_q, EXHAUSTED);
    check("order_pending_a", q_a.size(), 32'h0);
    check("order_pending_b", q_b.size(), 32'h0);

    // Fairness: core2 alone (masked after each grant), then cores 1 and 3 with rr_ptr=3.
    step(1'b1, 1'b0, 4'b0000);
    check("restart_exh_a", exh_a, 32'h0);
    check("restart_issued_a", iss_a, 32'h0);
    check("restart_busy_a", busy_a, 32'h1);
    expect_grant(0, 2, 8'h00, 8'h0F); expect_grant(0, 2, 8'h10, 8'h1F);
    expect_grant(0, 3, 8'h20, 8'h2F); expect_grant(0, 1, 8'h30, 8'h3F);
    expect_grant(1, 2, 8'h00, 8'h0F); expect_grant(1, 2, 8'h10, 8'h1F);
    expect_grant(1, 3, 8'h20, 8'h27);
    repeat (3) step(1'b0, 1'b0, 4'b0100);
    repeat (2) step(1'b0, 1'b0, 4'b1010);
    repeat (2) step(1'b0, 1'b0, 4'b0000);
    check("fair_pending_a", q_a.size(), 32'h0);
    check("fair_pending_b", q_b.size(), 32'h0);
    check("fair_issued_b", iss_b, 32'd3);

    // Stop collides with a request: no grant, state STOPPED, chunk outputs hold.
    step(1'b1, 1'b0, 4'b0000);
    expect_grant(0, 0, 8'h00, 8'h0F); expect_grant(0, 1, 8'h10, 8'h1F);
    expect_grant(1, 0, 8'h00, 8'h0F); expect_grant(1, 1, 8'h10, 8'h1F);
    step(1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 4'b0001);
    check("stop_state_a", dut_a.state_q, STOPPED);
    check("stop_state_b", dut_b.state_q, STOPPED);
    check("stop_busy_a", busy_a, 32'h0);
    check("stop_grant_a", grant_a, 32'h0);
    check("stop_hold_base", base_a, 32'h10);
    check("stop_hold_last", last_a, 32'h1F);
    check("stop_issued", iss_a, 32'd2);
    step(1'b0, 1'b0, 4'b0001);
    check("stopped_grant", grant_a, 32'h0);
    check("stopped_state", dut_a.state_q, STOPPED);

    // Restart from STOPPED begins again at key 0.
    step(1'b1, 1'b0, 4'b0000);
    check("rs_issued", iss_a, 32'h0);
    check("rs_busy", busy_a, 32'h1);
    expect_grant(0, 2, 8'h00, 8'h0F);
    expect_grant(1, 2, 8'h00, 8'h0F);
    step(1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b0, 4'b0000);
    check("rs_issued_after", iss_a, 32'd1);

    // Asynchronous reset while a grant is on the outputs.
    expect_grant(0, 0, 8'h10, 8'h1F);
    expect_grant(1, 0, 8'h10, 8'h1F);
    step(1'b0, 1'b0, 4'b0001);
    #1 reset = 1'b1;
    #1;
    check("arst_grant", grant_a, 32'h0);
    check("arst_busy", busy_a, 32'h0);
    check("arst_base", base_a, 32'h0);
    check("arst_last", last_b, 32'h0);
    check("arst_state", dut_a.state_q, IDLE);
    check("arst_issued", iss_b, 32'h0);
    #1 reset = 1'b0;
    core_req = 4'b0000;
    @(negedge clk);

    // stop in IDLE is ignored, and start+stop from IDLE does not start.
    step(1'b0, 1'b1, 4'b0000);
    check("idle_stop_state", dut_a.state_q, IDLE);
    step(1'b1, 1'b1, 4'b1111);
    check("idle_startstop_state", dut_a.state_q, IDLE);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);

    check("final_pending_a", q_a.size(), 32'h0);
    check("final_pending_b", q_b.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
